// File: rtl/alu_issue_queue.sv
// Issue queue for the 4-bit ALU: a FIFO of requests, the head drives the ALU, results land in a registered output stage.
// Latency: 1 edge from accept to alu_*, 2 edges to out_*; in_ready depends only on occupancy, out_* hold while stalled.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_a,
    input  logic [3:0]    in_b,
    input  logic [2:0]    in_op,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [7:0]    alu_result,
    input  logic          alu_zero,
    input  logic          alu_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_result,
    output logic          out_zero,
    output logic          out_carry,
    output logic [3:0]    out_a,
    output logic [3:0]    out_b,
    output logic [2:0]    out_op,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [3:0]    r_mem_a  [DEPTH];
    logic [3:0]    r_mem_b  [DEPTH];
    logic [2:0]    r_mem_op [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          r_out_valid;
    logic [7:0]    r_out_result;
    logic          r_out_zero;
    logic          r_out_carry;
    logic [3:0]    r_out_a;
    logic [3:0]    r_out_b;
    logic [2:0]    r_out_op;

    logic          w_not_empty;
    logic          w_push;
    logic          w_pop;

    assign w_not_empty = (r_count != '0);
    assign in_ready    = !rst && (r_count < FULL);
    assign w_push      = in_valid && in_ready && !flush;
    assign w_pop       = w_not_empty && (!r_out_valid || out_ready) && !flush;

    // Head entry is masked to zero when empty so the ALU sees a quiet input.
    assign alu_a  = w_not_empty ? r_mem_a[r_rptr]  : 4'd0;
    assign alu_b  = w_not_empty ? r_mem_b[r_rptr]  : 4'd0;
    assign alu_op = w_not_empty ? r_mem_op[r_rptr] : 3'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr]  <= in_a;
            r_mem_b[r_wptr]  <= in_b;
            r_mem_op[r_wptr] <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // Flush only drops the valid bit; data fields are cleared by reset alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= 8'd0;
            r_out_zero   <= 1'b0;
            r_out_carry  <= 1'b0;
            r_out_a      <= 4'd0;
            r_out_b      <= 4'd0;
            r_out_op     <= 3'd0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_zero   <= alu_zero;
            r_out_carry  <= alu_carry;
            r_out_a      <= alu_a;
            r_out_b      <= alu_b;
            r_out_op     <= alu_op;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_carry  = r_out_carry;
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_op     = r_out_op;
    assign count      = r_count;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU closing the loop.
module tb_alu_issue_queue;
    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_ready, out_valid;
    logic [3:0] in_a, in_b, alu_a, alu_b, out_a, out_b;
    logic [2:0] in_op, alu_op, out_op;
    logic [7:0] alu_result, out_result;
    logic       alu_zero, alu_carry, out_zero, out_carry;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
        .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .count(count)
    );

    // Stand-in ALU: op 0 is add with carry out of bit 4; other ops are an arbitrary but fixed mix.
    function automatic logic [9:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [7:0] r;
        logic       c;
        if (op == 3'd0) begin
            r = {4'd0, a} + {4'd0, b};
            c = r[4];
        end else begin
            r = {a, b} ^ {5'd0, op};
            c = op[0];
        end
        return {c, (r == 8'd0), r};
    endfunction

    logic [9:0] w_alu;
    assign w_alu      = alu_f(alu_a, alu_b, alu_op);
    assign alu_result = w_alu[7:0];
    assign alu_zero   = w_alu[8];
    assign alu_carry  = w_alu[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [9:0] e;
        e = alu_f(a, b, op);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_a"}, 32'(out_a), 32'(a));
        check({tag, "_b"}, 32'(out_b), 32'(b));
        check({tag, "_op"}, 32'(out_op), 32'(op));
        check({tag, "_res"}, 32'(out_result), 32'(e[7:0]));
        check({tag, "_zc"}, 32'({out_carry, out_zero}), 32'(e[9:8]));
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 4'h7, 4'h2, 3'd0);

        // Reset held two cycles with a request offered
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_count", 32'(count), 32'd0);
            check("rst_out_data", 32'({out_result, out_zero, out_carry, out_a, out_b, out_op}), 32'd0);
            check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        end
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Single add 3 + 5
        out_ready = 1'b1;
        drive(1'b1, 4'b0011, 4'b0101, 3'b000);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        check("add_alu", 32'({alu_a, alu_b, alu_op}), 32'({4'b0011, 4'b0101, 3'b000}));
        check("add_count1", 32'(count), 32'd1);
        check("add_vld_early", 32'(out_valid), 32'd0);
        tick();
        check("add_vld", 32'(out_valid), 32'd1);
        check("add_res", 32'(out_result), 32'h08);
        check("add_zero", 32'(out_zero), 32'd0);
        check("add_op", 32'(out_op), 32'd0);
        check("add_count0", 32'(count), 32'd0);
        check("add_alu_empty", 32'({alu_a, alu_b, alu_op}), 32'd0);
        tick();
        check("add_vld_fall", 32'(out_valid), 32'd0);

        // Zero flag, then 15 + 1 carry, back to back
        drive(1'b1, 4'h0, 4'h0, 3'd0);
        tick();
        drive(1'b1, 4'hF, 4'h1, 3'd0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        check("zf_vld", 32'(out_valid), 32'd1);
        check("zf_res", 32'(out_result), 32'h00);
        check("zf_zero", 32'(out_zero), 32'd1);
        check("zf_carry", 32'(out_carry), 32'd0);
        tick();
        check("ord_vld", 32'(out_valid), 32'd1);
        check("ord_res", 32'(out_result), 32'h10);
        check("ord_zero", 32'(out_zero), 32'd0);
        check("ord_carry", 32'(out_carry), 32'd1);
        tick();
        check("ord_vld_fall", 32'(out_valid), 32'd0);

        // Backpressure: five requests fill output stage plus FIFO
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'(k + 1), 4'hA, 3'(k + 1));
            check("bp_accept_rdy", 32'(in_ready), 32'd1);
            tick();
        end
        drive(1'b1, 4'hC, 4'hC, 3'd7);
        check("bp_count_full", 32'(count), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check_out("bp_hold0", 4'd1, 4'hA, 3'd1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        check_out("bp_hold1", 4'd1, 4'hA, 3'd1);
        check("bp_head", 32'({alu_a, alu_b, alu_op}), 32'({4'd2, 4'hA, 3'd2}));
        check("bp_count_still", 32'(count), 32'd4);
        out_ready = 1'b1;
        #1;
        check("bp_full_pop_rdy", 32'(in_ready), 32'd0);
        for (int k = 1; k < 5; k++) begin
            tick();
            check_out("bp_drain", 4'(k + 1), 4'hA, 3'(k + 1));
            check("bp_drain_count", 32'(count), 32'(4 - k));
        end
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Build count = 2 behind a stalled output, then stream with push and pop together
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 4'(j), ~4'(j), 3'(j));
            tick();
        end
        check("pp_count_start", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            drive(1'b1, 4'(m + 2), ~4'(m + 2), 3'(m + 2));
            tick();
            check("pp_count", 32'(count), 32'd2);
            check_out("pp_out", 4'(m), ~4'(m), 3'(m));
        end
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        tick();
        check_out("pp_tail13", 4'd13, ~4'd13, 3'd5);
        check("pp_tail_count1", 32'(count), 32'd1);
        tick();
        check_out("pp_tail14", 4'd14, ~4'd14, 3'd6);
        check("pp_tail_count0", 32'(count), 32'd0);
        tick();
        check("pp_done", 32'(out_valid), 32'd0);

        // Flush with count = 3, out_valid = 1 and a request offered
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 4'(j + 8), 4'(j), 3'd0);
            tick();
        end
        check("fl_pre_count", 32'(count), 32'd3);
        check("fl_pre_vld", 32'(out_valid), 32'd1);
        drive(1'b1, 4'h9, 4'h9, 3'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        check("fl_count", 32'(count), 32'd0);
        check("fl_vld", 32'(out_valid), 32'd0);
        check("fl_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("fl_not_accepted", 32'(count), 32'd0);
        check("fl_no_late_out", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
